// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris input path.
//   action_t : action codes carried from the DAS blocks to the game logic
//   N_ACT    : number of action channels (one per action_t member)
//   CODE_W   : width of an encoded action code
package tetris_pkg;

  typedef enum logic [2:0] {
    ACT_LEFT      = 3'd0,
    ACT_RIGHT     = 3'd1,
    ACT_ROT_CW    = 3'd2,
    ACT_ROT_CCW   = 3'd3,
    ACT_SOFT_DROP = 3'd4,
    ACT_HARD_DROP = 3'd5
  } action_t;

  localparam int N_ACT  = 6;
  localparam int CODE_W = $bits(action_t);

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous command queue with a single-cycle flush-and-load.
// Ports:
//   clk, rst_l : clock, asynchronous active-low reset
//   push       : write push_data at the tail (ignored while full)
//   pop        : drop the head entry (ignored while empty)
//   flush      : clear all entries and load push_data as the only entry;
//                overrides push and pop in the same cycle
//   push_data  : entry to write
//   count      : number of entries held (0..DEPTH)
//   head       : entry at the head, 0 while empty
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
      mem[0] <= push_data;
      wr_ptr <= PTR_W'(1);
      rd_ptr <= '0;
      count  <= CNT_W'(1);
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/action_dispatcher.sv
// Collects single-cycle action pulses from the DAS blocks, holds them as
// pending bits, and feeds them one per cycle (highest code first) into a
// command queue read by the game logic.
// Ports:
//   clk, rst_l    : clock, asynchronous active-low reset
//   action_pulse  : per-channel request pulses, bit i = action code i
//   action_valid  : per-channel accept-enable back to the DAS blocks
//   input_lock    : game-side hold; blocks acceptance, not draining/popping
//   cmd_valid     : queue head holds a command
//   cmd_code      : code at the queue head (0 while empty)
//   cmd_ready     : game logic consumes the head command
//   fifo_count    : number of queued commands
// Build option: define HARD_DROP_FLUSH_EN to make a HARD_DROP grant flush the
// queue and the other pending bits, leaving HARD_DROP as the only command.
module action_dispatcher #(
  parameter int N_ACT      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [N_ACT-1:0]              action_pulse,
  output logic [N_ACT-1:0]              action_valid,
  input  logic                          input_lock,
  output logic                          cmd_valid,
  output logic [$clog2(N_ACT)-1:0]      cmd_code,
  input  logic                          cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import tetris_pkg::*;

  localparam int CW    = $clog2(N_ACT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [N_ACT-1:0] pending;
  logic [N_ACT-1:0] accept;
  logic [N_ACT-1:0] grant_mask;
  logic [CW-1:0]    grant_code;
  logic             fifo_full;
  logic             push;
  logic             flush;
  logic             pop;

  // Gated by rst_l so the DAS blocks see no accept-enable during reset.
  assign action_valid = rst_l ? (~pending & {N_ACT{~input_lock}}) : '0;
  assign accept       = action_pulse & action_valid;

  // Highest-index pending bit wins; later iterations override earlier ones.
  always_comb begin
    grant_code = '0;
    for (int i = 0; i < N_ACT; i++) begin
      if (pending[i]) grant_code = CW'(i);
    end
    grant_mask = N_ACT'(1) << grant_code;
  end

  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

`ifdef HARD_DROP_FLUSH_EN
  // A HARD_DROP grant does not wait for space: it replaces the queue.
  assign flush = (|pending) && (grant_code == CW'(ACT_HARD_DROP));
  assign push  = (|pending) && !fifo_full && !flush;
`else
  assign flush = 1'b0;
  // Full is judged before any same-cycle pop, so a pop never frees a slot
  // for the grant in the same edge.
  assign push  = (|pending) && !fifo_full;
`endif

  assign pop = cmd_valid && cmd_ready;

  // A bit can only be accepted while clear, so accept never overlaps the
  // granted bit.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)     pending <= '0;
    else if (flush) pending <= accept;
    else if (push)  pending <= (pending & ~grant_mask) | accept;
    else            pending <= pending | accept;
  end

  sync_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (grant_code),
    .count     (fifo_count),
    .head      (cmd_code)
  );

  assign cmd_valid = (fifo_count != '0);

endmodule

// File: tb/tb_action_dispatcher.sv
module tb_action_dispatcher;

  localparam int N = 6;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic [N-1:0] action_pulse = '0;
  logic [N-1:0] action_valid;
  logic         input_lock = 1'b0;
  logic         cmd_valid;
  logic [2:0]   cmd_code;
  logic         cmd_ready = 1'b0;
  logic [2:0]   fifo_count;

  action_dispatcher #(.N_ACT(N), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .action_pulse (action_pulse),
    .action_valid (action_valid),
    .input_lock   (input_lock),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_ready    (cmd_ready),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int delivered = 0;

  // Reference model: set of pending actions and the ordered list of commands.
  bit [N-1:0] m_pend;
  int         m_q[$];
  int         sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge: pop the head if consumed, grant the highest
  // pending action if there is room, then record newly accepted pulses.
  initial begin
    forever begin
      @(posedge clk or negedge rst_l);
      if (!rst_l) begin
        m_pend = '0;
        m_q.delete();
        sb_q.delete();
      end else begin
        bit [N-1:0] acc;
        int         hi;
        bit         full;
        acc  = input_lock ? '0 : (action_pulse & ~m_pend);
        hi   = -1;
        for (int i = 0; i < N; i++) if (m_pend[i]) hi = i;
        full = (m_q.size() == D);
        if (m_q.size() != 0 && cmd_ready) void'(m_q.pop_front());
        if (hi >= 0) begin
`ifdef HARD_DROP_FLUSH_EN
          if (hi == 5) begin
            m_q.delete();  m_q.push_back(5);
            sb_q.delete(); sb_q.push_back(5);
            m_pend = '0;
          end else
`endif
          if (!full) begin
            m_q.push_back(hi);
            sb_q.push_back(hi);
            m_pend[hi] = 1'b0;
          end
        end
        m_pend = m_pend | acc;
      end
    end
  end

  // Monitor: every cycle compare observable state; on each handshake pop the
  // scoreboard and compare the delivered code.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        check("rst_action_valid", int'(action_valid), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
      end else begin
        check("action_valid", int'(action_valid),
              input_lock ? 0 : int'(~m_pend & 6'h3f));
        check("fifo_count", int'(fifo_count), m_q.size());
        check("cmd_valid", int'(cmd_valid), (m_q.size() != 0) ? 1 : 0);
        if (cmd_valid && cmd_ready) begin
          if (sb_q.size() == 0) check("sb_underflow", 0, 1);
          else check("cmd_code", int'(cmd_code), sb_q.pop_front());
          delivered++;
        end else if (!cmd_valid) begin
          check("empty_code", int'(cmd_code), 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [N-1:0] p, input logic l, input logic r);
    action_pulse = p;
    input_lock   = l;
    cmd_ready    = r;
    @(posedge clk);
    #1;
    action_pulse = '0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((cmd_valid || action_valid != 6'h3f) && i < 60) begin
      drive('0, 1'b0, 1'b1);
      i++;
    end
    check("drain_count", int'(fifo_count), 0);
    check("drain_pending", int'(action_valid), 6'h3f);
    drive('0, 1'b0, 1'b0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_valid", int'(cmd_valid), 0);
    check("reset_fifo_count", int'(fifo_count), 0);
    check("reset_action_valid", int'(action_valid), 0);
    check("reset_cmd_code", int'(cmd_code), 0);
    rst_l = 1'b1;

    // LEFT latency: pending edge, then push edge.
    drive(6'b000001, 1'b0, 1'b0);
    check("lat_valid_early", int'(cmd_valid), 0);
    drive('0, 1'b0, 1'b0);
    check("lat_valid", int'(cmd_valid), 1);
    check("lat_code", int'(cmd_code), 0);
    check("lat_count", int'(fifo_count), 1);
    drain();

    // Three simultaneous pulses: pushed as 4, 2, 0.
    drive(6'b010101, 1'b0, 1'b0);
    check("arb_av0_a", int'(action_valid[0]), 0);
    drive('0, 1'b0, 1'b0);
    check("arb_head", int'(cmd_code), 4);
    check("arb_av0_b", int'(action_valid[0]), 0);
    drive('0, 1'b0, 1'b0);
    check("arb_av0_c", int'(action_valid[0]), 0);
    drive('0, 1'b0, 1'b0);
    check("arb_count", int'(fifo_count), 3);
    check("arb_av0_d", int'(action_valid[0]), 1);
    drain();

    // Saturation: all six at once with the consumer stalled.
    d0 = delivered;
    drive(6'h3f, 1'b0, 1'b0);
    repeat (6) drive('0, 1'b0, 1'b0);
`ifdef HARD_DROP_FLUSH_EN
    check("sat_count", int'(fifo_count), 1);
    check("sat_pending", $countones(~action_valid), 0);
`else
    check("sat_count", int'(fifo_count), 4);
    check("sat_pending", $countones(~action_valid), 2);
`endif
    drain();
`ifdef HARD_DROP_FLUSH_EN
    check("sat_delivered", delivered - d0, 1);
`else
    check("sat_delivered", delivered - d0, 6);
`endif

    // Lock: RIGHT ignored, queued LEFT still pops.
    drive(6'b000001, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    drive(6'b000010, 1'b1, 1'b0);
    check("lock_av", int'(action_valid), 0);
    check("lock_count", int'(fifo_count), 1);
    drive('0, 1'b1, 1'b1);
    drive('0, 1'b1, 1'b0);
    check("lock_popped", int'(fifo_count), 0);
    drive('0, 1'b0, 1'b0);
    check("lock_no_right", int'(action_valid), 6'h3f);

    // Queue {0,1,2}, then HARD_DROP.
    drive(6'b000001, 1'b0, 1'b0);
    drive(6'b000010, 1'b0, 1'b0);
    drive(6'b000100, 1'b0, 1'b0);
    drive(6'b100000, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
`ifdef HARD_DROP_FLUSH_EN
    check("hd_count", int'(fifo_count), 1);
    check("hd_code", int'(cmd_code), 5);
`else
    check("hd_count", int'(fifo_count), 4);
    check("hd_code", int'(cmd_code), 0);
`endif
    drain();

    // Reset mid-stream with three queued.
    drive(6'b000001, 1'b0, 1'b0);
    drive(6'b000010, 1'b0, 1'b0);
    drive(6'b000100, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    check("mid_count", int'(fifo_count), 3);
    #2;
    rst_l = 1'b0;
    #1;
    check("mid_rst_valid", int'(cmd_valid), 0);
    check("mid_rst_count", int'(fifo_count), 0);
    check("mid_rst_av", int'(action_valid), 0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    drive(6'b001000, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    check("post_rst_valid", int'(cmd_valid), 1);
    check("post_rst_code", int'(cmd_code), 3);
    check("post_rst_count", int'(fifo_count), 1);
    drain();

    // Randomized traffic with occasional lock, stalls and resets.
    for (int k = 0; k < 1500; k++) begin
      logic [N-1:0] p;
      p = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      drive(p, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 299) == 0) begin
        rst_l = 1'b0;
        @(posedge clk);
        #1;
        rst_l = 1'b1;
      end
    end
    input_lock = 1'b0;
    drain();
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/action_dispatcher.md
ACTION_DISPATCHER -- requirements
Module: action_dispatcher

Interface
REQ-001 SHALL have parameter N_ACT, default 6, number of action channels; its value is fixed by the package action enum.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command queue depth; power of 2, at least 2.
REQ-003 SHALL have port clk  in  1  clock; all state changes on posedge.
REQ-004 SHALL have port rst_l  in  1  reset: asynchronous, active-low.
REQ-005 SHALL have port action_pulse  in  N_ACT  single-cycle action requests from the per-button DAS blocks; bit i is action code i.
REQ-006 SHALL have port action_valid  out  N_ACT  per-channel accept-enable, returned to the DAS blocks.
REQ-007 SHALL have port input_lock  in  1  game-side hold (line clear, spawn); blocks new acceptance.
REQ-008 SHALL have port cmd_valid  out  1  a command is available at the queue head.
REQ-009 SHALL have port cmd_code  out  $clog2(N_ACT)  action code at the queue head.
REQ-010 SHALL have port cmd_ready  in  1  the game logic consumes the head command.
REQ-011 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued commands.

Function
REQ-012 SHALL use codes 0 LEFT, 1 RIGHT, 2 ROT_CW, 3 ROT_CCW, 4 SOFT_DROP, 5 HARD_DROP.
REQ-013 SHALL compute action_valid[i] combinationally as !pending[i] && !input_lock.
REQ-014 SHALL set pending[i] at the edge where action_pulse[i] && action_valid[i]; a pulse with action_valid[i] low SHALL be ignored.
REQ-015 SHALL, at each edge where pending is nonzero and the queue is not full, grant the highest-index pending bit, clear that bit, and push its code.
REQ-016 SHALL grant at most one push per cycle; other pending bits SHALL wait, retained.
REQ-017 SHALL show a new action on cmd_valid/cmd_code two cycles after its pulse edge when the queue is empty and the action is uncontended (pending edge, then push edge).
REQ-018 SHALL drive cmd_valid = (fifo_count != 0) and cmd_code = head entry; when empty, cmd_code SHALL be 0.
REQ-019 SHALL pop at each edge where cmd_valid && cmd_ready; cmd_ready while empty SHALL have no effect.
REQ-020 SHALL block a push while full, even when a pop occurs the same cycle; the grant waits and pending holds.
REQ-021 SHALL, on a simultaneous push and pop when not full, keep fifo_count unchanged and preserve order.
REQ-022 SHALL, while input_lock is high, continue draining pending into the queue and continue popping; only acceptance is blocked.
REQ-023 SHALL handle read/write pointer wrap-around modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-024 SHALL, on rst_l low, asynchronously clear pending, the pointers and fifo_count, giving cmd_valid=0, cmd_code=0 and fifo_count=0.
REQ-025 SHALL force action_valid to all-zero while rst_l is low.
REQ-026 SHALL discard all queued and pending actions on reset mid-operation; there SHALL be no replay after release.

Configuration
REQ-027 SHALL, with macro HARD_DROP_FLUSH_EN defined, treat a HARD_DROP grant as follows: clear all queue entries, write HARD_DROP as the sole entry, set fifo_count=1, and clear all other pending bits, all at the same edge.
REQ-028 SHALL, with HARD_DROP_FLUSH_EN defined, let a HARD_DROP grant proceed while the queue is full (flush overrides REQ-020); a head popped in that same cycle counts as consumed.
REQ-029 SHALL, without HARD_DROP_FLUSH_EN, queue HARD_DROP like any other code.

Structure
REQ-030 SHALL take the action_t enum, N_ACT and the code widths from the shared package tetris_pkg.
REQ-031 SHALL place the queue in the sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, flush, count, head). The arbiter and pending logic SHALL live in the top level.

Verification
REQ-032 SHALL cover: reset release, then a LEFT pulse at edge 0 with cmd_ready=0 -> cmd_valid=1, cmd_code=0 after edge 1; fifo_count=1.
REQ-033 SHALL cover: LEFT, ROT_CW and SOFT_DROP pulsed in the same cycle -> pushes in order 4, 2, 0 on three consecutive edges; action_valid[0] low until its grant.
REQ-034 SHALL cover: cmd_ready=0 and 6 distinct pulses -> fifo_count saturates at 4 and 2 bits stay pending; cmd_ready=1 -> all 6 are delivered, none lost.
REQ-035 SHALL cover: input_lock=1 with 1 entry queued and a RIGHT pulse -> RIGHT ignored, action_valid=0, the queued entry still pops.
REQ-036 SHALL cover: with HARD_DROP_FLUSH_EN, queue {0,1,2} then a HARD_DROP pulse -> fifo_count=1 and cmd_code=5 the edge after the grant; without the macro -> fifo_count=4 and 5 at the tail.
REQ-037 SHALL cover: rst_l asserted mid-stream with 3 queued -> immediately cmd_valid=0 and fifo_count=0; after release the next pulse is delivered in 2 cycles.
